// File: rtl/mem_stage_pkg.sv
// Shared constants and helpers for the MEM pipeline stage: datapath sizes,
// memory-mapped I/O addresses and the writeback-select encoding.
package mem_stage_pkg;

   localparam int DBITS         = 32;
   localparam int MEM_ADDR_BITS = 11;

   localparam logic [DBITS-1:0] ADDR_HEX  = 32'hF000_0000;
   localparam logic [DBITS-1:0] ADDR_LEDR = 32'hF000_0004;
   localparam logic [DBITS-1:0] ADDR_KEY  = 32'hF000_0010;
   localparam logic [DBITS-1:0] ADDR_SW   = 32'hF000_0014;
   localparam logic [DBITS-1:0] WORD_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_PC  = 2'd1,
      WB_MEM = 2'd2
   } wb_sel_t;

   // Load data outranks the link address, which outranks the ALU result.
   function automatic wb_sel_t wb_select(input logic memtoreg, input logic jal);
      wb_sel_t sel;
      if (memtoreg) begin
         sel = WB_MEM;
      end else if (jal) begin
         sel = WB_PC;
      end else begin
         sel = WB_ALU;
      end
      return sel;
   endfunction

   function automatic logic is_ram(input logic [DBITS-1:0] addr);
      return (addr[DBITS-1:MEM_ADDR_BITS+2] == {(DBITS-MEM_ADDR_BITS-2){1'b0}});
   endfunction

endpackage

// File: rtl/mem_stage_data_ram.sv
// Single-port data RAM with synchronous read (read-before-write), no reset on
// the array or read register so it maps onto block RAM.
module mem_stage_data_ram #(
   parameter int AW = 11,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];

   // Write port and registered read share one address.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      o_rdata <= r_mem[i_addr];
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data RAM and MMIO access, input synchronizers, MEM/WB
// register, writeback mux and MEM-stage forwarding outputs.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             memtoReg_m,
   input  logic             memWrite_m,
   input  logic             jal_m,
   input  logic             regWrite_m,
   input  logic [DBITS-1:0] incrementedPC_m,
   input  logic [DBITS-1:0] dstReg_m,
   input  logic [DBITS-1:0] aluOut_m,
   input  logic [DBITS-1:0] dataFwdOut2_m,
   input  logic [3:0]       key,
   input  logic [9:0]       sw,
   output logic [23:0]      hex,
   output logic [9:0]       ledr,
   output logic [DBITS-1:0] fwdValue_m,
   output logic             fwdValid_m,
   output logic             regWrite_w,
   output logic [DBITS-1:0] dstReg_w,
   output logic [DBITS-1:0] wbData_w
);

   logic [DBITS-1:0] w_addr;
   logic             w_ram_hit;
   logic             w_ram_we;
   logic [DBITS-1:0] w_ram_q;
   logic [DBITS-1:0] w_mmio_rdata;
   logic [DBITS-1:0] w_read_data;

   logic [23:0]      r_hex;
   logic [9:0]       r_ledr;
   logic [3:0]       r_key_s1, r_key_s2;
   logic [9:0]       r_sw_s1, r_sw_s2;
   logic             r_reg_write;
   logic [DBITS-1:0] r_dst;
   wb_sel_t          r_wb_sel;
   logic [DBITS-1:0] r_alu;
   logic [DBITS-1:0] r_pc;
   logic [DBITS-1:0] r_mmio_rdata;
   logic             r_rd_ram;

   assign w_addr    = aluOut_m & WORD_MASK;
   assign w_ram_hit = is_ram(aluOut_m);
   // Gating with reset_n keeps a pending store from landing while held in reset.
   assign w_ram_we  = memWrite_m & w_ram_hit & reset_n;

   mem_stage_data_ram #(
      .AW(MEM_ADDR_BITS),
      .DW(DBITS)
   ) u_data_ram (
      .clk    (clk),
      .i_we   (w_ram_we),
      .i_addr (aluOut_m[MEM_ADDR_BITS+1:2]),
      .i_wdata(dataFwdOut2_m),
      .o_rdata(w_ram_q)
   );

   // MMIO read mux, zero-extended; unmapped addresses read as zero.
   always_comb begin
      w_mmio_rdata = {DBITS{1'b0}};
      if (w_addr == ADDR_HEX) begin
         w_mmio_rdata = {{(DBITS-24){1'b0}}, r_hex};
      end else if (w_addr == ADDR_LEDR) begin
         w_mmio_rdata = {{(DBITS-10){1'b0}}, r_ledr};
      end else if (w_addr == ADDR_KEY) begin
         w_mmio_rdata = {{(DBITS-4){1'b0}}, r_key_s2};
      end else if (w_addr == ADDR_SW) begin
         w_mmio_rdata = {{(DBITS-10){1'b0}}, r_sw_s2};
      end else begin
         w_mmio_rdata = {DBITS{1'b0}};
      end
   end

   // Writable MMIO registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hex  <= 24'h00_0000;
         r_ledr <= 10'h000;
      end else begin
         if (memWrite_m && (w_addr == ADDR_HEX)) begin
            r_hex <= dataFwdOut2_m[23:0];
         end
         if (memWrite_m && (w_addr == ADDR_LEDR)) begin
            r_ledr <= dataFwdOut2_m[9:0];
         end
      end
   end

   // Two-flop synchronizers for the asynchronous board inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_key_s1 <= 4'h0;
         r_key_s2 <= 4'h0;
         r_sw_s1  <= 10'h000;
         r_sw_s2  <= 10'h000;
      end else begin
         r_key_s1 <= key;
         r_key_s2 <= r_key_s1;
         r_sw_s1  <= sw;
         r_sw_s2  <= r_sw_s1;
      end
   end

   // MEM/WB boundary register; RAM read data is registered inside the RAM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_reg_write  <= 1'b0;
         r_dst        <= {DBITS{1'b0}};
         r_wb_sel     <= WB_ALU;
         r_alu        <= {DBITS{1'b0}};
         r_pc         <= {DBITS{1'b0}};
         r_mmio_rdata <= {DBITS{1'b0}};
         r_rd_ram     <= 1'b0;
      end else begin
         r_reg_write  <= regWrite_m;
         r_dst        <= dstReg_m;
         r_wb_sel     <= wb_select(memtoReg_m, jal_m);
         r_alu        <= aluOut_m;
         r_pc         <= incrementedPC_m;
         r_mmio_rdata <= w_mmio_rdata;
         r_rd_ram     <= w_ram_hit;
      end
   end

   assign w_read_data = r_rd_ram ? w_ram_q : r_mmio_rdata;

   // Writeback data select.
   always_comb begin
      wbData_w = r_alu;
      case (r_wb_sel)
         WB_MEM:  wbData_w = w_read_data;
         WB_PC:   wbData_w = r_pc;
         WB_ALU:  wbData_w = r_alu;
         default: wbData_w = r_alu;
      endcase
   end

   assign regWrite_w = r_reg_write;
   assign dstReg_w   = r_dst;
   assign hex        = r_hex;
   assign ledr       = r_ledr;
   assign fwdValue_m = jal_m ? incrementedPC_m : aluOut_m;
   assign fwdValid_m = regWrite_m & ~memtoReg_m;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a word-addressed memory/MMIO model,
// with directed literal checks from the stage's documented scenarios.
module tb_mem_stage;

   logic        clk;
   logic        reset_n;
   logic        memtoReg_m, memWrite_m, jal_m, regWrite_m;
   logic [31:0] incrementedPC_m, dstReg_m, aluOut_m, dataFwdOut2_m;
   logic [3:0]  key;
   logic [9:0]  sw;
   logic [23:0] hex;
   logic [9:0]  ledr;
   logic [31:0] fwdValue_m;
   logic        fwdValid_m;
   logic        regWrite_w;
   logic [31:0] dstReg_w;
   logic [31:0] wbData_w;

   mem_stage dut (
      .clk(clk), .reset_n(reset_n),
      .memtoReg_m(memtoReg_m), .memWrite_m(memWrite_m), .jal_m(jal_m),
      .regWrite_m(regWrite_m), .incrementedPC_m(incrementedPC_m),
      .dstReg_m(dstReg_m), .aluOut_m(aluOut_m), .dataFwdOut2_m(dataFwdOut2_m),
      .key(key), .sw(sw), .hex(hex), .ledr(ledr),
      .fwdValue_m(fwdValue_m), .fwdValid_m(fwdValid_m),
      .regWrite_w(regWrite_w), .dstReg_w(dstReg_w), .wbData_w(wbData_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Behavioural model state
   logic [31:0] m_ram [int];
   logic [23:0] m_hex;
   logic [9:0]  m_ledr;
   logic [3:0]  m_key_h1, m_key_h2;
   logic [9:0]  m_sw_h1, m_sw_h2;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] w;
      w = a & 32'hFFFF_FFFC;
      if (w < 32'h0000_2000) return m_ram.exists(int'(w >> 2)) ? m_ram[int'(w >> 2)] : 32'h0;
      if (w == 32'hF000_0000) return {8'h00, m_hex};
      if (w == 32'hF000_0004) return {22'h0, m_ledr};
      if (w == 32'hF000_0010) return {28'h0, m_key_h2};
      if (w == 32'hF000_0014) return {22'h0, m_sw_h2};
      return 32'h0;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] w;
      w = a & 32'hFFFF_FFFC;
      if (w < 32'h0000_2000) m_ram[int'(w >> 2)] = d;
      else if (w == 32'hF000_0000) m_hex = d[23:0];
      else if (w == 32'hF000_0004) m_ledr = d[9:0];
   endtask

   task automatic model_reset();
      m_hex = 24'h0; m_ledr = 10'h0;
      m_key_h1 = 4'h0; m_key_h2 = 4'h0;
      m_sw_h1 = 10'h0; m_sw_h2 = 10'h0;
   endtask

   logic [31:0] e_wb;
   logic        e_rw;
   logic [31:0] e_dst;

   // Compare process: predict this edge's results from the sampled inputs.
   always @(posedge clk) begin
      if (chk_en) begin
         chk("fwdValue", fwdValue_m, jal_m ? incrementedPC_m : aluOut_m);
         chk("fwdValid", {31'h0, fwdValid_m}, {31'h0, regWrite_m && !memtoReg_m});
         e_rw  = regWrite_m;
         e_dst = dstReg_m;
         if (memtoReg_m) e_wb = model_read(aluOut_m);
         else if (jal_m) e_wb = incrementedPC_m;
         else            e_wb = aluOut_m;
         if (memWrite_m) model_store(aluOut_m, dataFwdOut2_m);
         m_key_h2 = m_key_h1; m_key_h1 = key;
         m_sw_h2  = m_sw_h1;  m_sw_h1  = sw;
         #1;
         chk("regWrite_w", {31'h0, regWrite_w}, {31'h0, e_rw});
         chk("dstReg_w", dstReg_w, e_dst);
         chk("wbData_w", wbData_w, e_wb);
         chk("hex", {8'h0, hex}, {8'h0, m_hex});
         chk("ledr", {22'h0, ledr}, {22'h0, m_ledr});
      end
   end

   task automatic op(input logic mr, input logic mw, input logic jl, input logic rw,
                     input logic [31:0] pc, input logic [31:0] dst,
                     input logic [31:0] alu, input logic [31:0] dat);
      @(negedge clk);
      memtoReg_m = mr; memWrite_m = mw; jal_m = jl; regWrite_m = rw;
      incrementedPC_m = pc; dstReg_m = dst; aluOut_m = alu; dataFwdOut2_m = dat;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   logic [31:0] mm [4];
   logic [31:0] a;
   int          k;

   initial begin
      mm = '{32'hF000_0000, 32'hF000_0004, 32'hF000_0010, 32'hF000_0014};
      reset_n = 1'b0;
      memtoReg_m = 1'b0; memWrite_m = 1'b0; jal_m = 1'b0; regWrite_m = 1'b0;
      incrementedPC_m = 32'h0; dstReg_m = 32'h0; aluOut_m = 32'h0; dataFwdOut2_m = 32'h0;
      key = 4'h0; sw = 10'h0;
      model_reset();
      #1;
      chk("reset regWrite_w", {31'h0, regWrite_w}, 32'h0);
      chk("reset wbData_w", wbData_w, 32'h0);
      chk("reset hex", {8'h0, hex}, 32'h0);
      chk("reset ledr", {22'h0, ledr}, 32'h0);
      chk("reset dstReg_w", dstReg_w, 32'h0);
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      chk_en = 1'b1;

      for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'(i * 4), $urandom);

      // RAM store/load, low address bits ignored
      op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0010, 32'hDEAD_BEEF);
      op(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'd5, 32'h0000_0010, 32'h0);
      after_edge();
      chk("lit ram load", wbData_w, 32'hDEAD_BEEF);
      chk("lit ram regWrite", {31'h0, regWrite_w}, 32'h1);
      chk("lit ram dst", dstReg_w, 32'd5);
      op(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'd6, 32'h0000_0013, 32'h0);
      after_edge();
      chk("lit ram load lowbits", wbData_w, 32'hDEAD_BEEF);

      // MMIO writes
      op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hF000_0000, 32'h00AB_CDEF);
      after_edge();
      chk("lit hex", {8'h0, hex}, 32'h00AB_CDEF);
      op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hF000_0004, 32'h0000_03FF);
      after_edge();
      chk("lit ledr", {22'h0, ledr}, 32'h0000_03FF);
      op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hF000_0014, 32'h1234_5678);
      after_edge();
      chk("lit sw store hex", {8'h0, hex}, 32'h00AB_CDEF);
      chk("lit sw store ledr", {22'h0, ledr}, 32'h0000_03FF);

      // Switch synchronizer latency and unmapped read
      op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      sw = 10'h155;
      op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      op(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'd7, 32'hF000_0014, 32'h0);
      after_edge();
      chk("lit sw load", wbData_w, 32'h0000_0155);
      op(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'd8, 32'h8000_0000, 32'h0);
      after_edge();
      chk("lit unmapped", wbData_w, 32'h0);

      // Writeback select and forwarding
      op(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0104, 32'd31, 32'h0000_0007, 32'h0);
      #1;
      chk("lit fwdValue jal", fwdValue_m, 32'h0000_0104);
      chk("lit fwdValid jal", {31'h0, fwdValid_m}, 32'h1);
      after_edge();
      chk("lit wb jal", wbData_w, 32'h0000_0104);
      op(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'd9, 32'h0000_0010, 32'h0);
      #1;
      chk("lit fwdValid load", {31'h0, fwdValid_m}, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 7);
         case (k)
            0: begin
               a = ($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
               op(1'b0, 1'b1, 1'b0, 1'b0, $urandom, $urandom, a, $urandom);
            end
            1, 2: begin
               a = ($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
               op(1'b1, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom, a, $urandom);
            end
            3: begin
               a = mm[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
               op(1'b0, 1'b1, 1'b0, 1'b0, $urandom, $urandom, a, $urandom);
            end
            4: begin
               a = mm[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
               op(1'b1, 1'b0, 1'b0, 1'b1, $urandom, $urandom, a, $urandom);
            end
            5: begin
               a = $urandom;
               a[31:28] = 4'h4;
               a[13] = 1'b1;
               op(1'($urandom), 1'($urandom), 1'b0, 1'b1, $urandom, $urandom, a, $urandom);
            end
            default: op(1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom);
         endcase
         if ($urandom_range(0, 5) == 0) sw = 10'($urandom);
         if ($urandom_range(0, 5) == 0) key = 4'($urandom);
      end

      // Asynchronous reset between edges with a HEX store pending
      op(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'd3, 32'hF000_0004, 32'h0000_0155);
      op(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'd4, 32'hF000_0000, 32'h0022_2222);
      #2;
      chk_en = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("async rst regWrite_w", {31'h0, regWrite_w}, 32'h0);
      chk("async rst hex", {8'h0, hex}, 32'h0);
      chk("async rst ledr", {22'h0, ledr}, 32'h0);
      chk("async rst wbData_w", wbData_w, 32'h0);
      after_edge();
      chk("rst held hex", {8'h0, hex}, 32'h0);
      op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      reset_n = 1'b1;
      model_reset();
      chk_en = 1'b1;
      after_edge();
      chk("post rst hex", {8'h0, hex}, 32'h0);
      op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hF000_0000, 32'h005A_5A5A);
      after_edge();
      chk("post rst store hex", {8'h0, hex}, 32'h005A_5A5A);
      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 15) << 2);
         op(1'($urandom), 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom, a, $urandom);
      end

      op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      after_edge();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline. Consumes the EX/MEM register outputs (memtoReg_m, memWrite_m, jal_m, regWrite_m, incrementedPC_m, dstReg_m, aluOut_m, dataFwdOut2_m).
- Performs data-RAM and memory-mapped I/O access, then registers results into the MEM/WB boundary.
- Drives writeback data, writeback enable and destination to the register file.
- Exports MEM-stage forwarding values to the hazard/forwarding unit.

Parameters:
- DBITS, 32, datapath width.
- MEM_ADDR_BITS, 11, log2 of data-RAM depth in words (2048 words).
- ADDR_HEX, 32'hF0000000, HEX display register address (R/W, low 24 bits used).
- ADDR_LEDR, 32'hF0000004, LED register address (R/W, low 10 bits used).
- ADDR_KEY, 32'hF0000010, pushbutton address (read-only, 4 bits).
- ADDR_SW, 32'hF0000014, switch address (read-only, 10 bits).

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- memtoReg_m  in  1  instruction in MEM is a load
- memWrite_m  in  1  store enable
- jal_m  in  1  writeback selects incrementedPC_m
- regWrite_m  in  1  register writeback enable
- incrementedPC_m  in  DBITS  PC+4 of instruction in MEM
- dstReg_m  in  DBITS  destination register index
- aluOut_m  in  DBITS  byte address / ALU result
- dataFwdOut2_m  in  DBITS  store data
- key  in  4  raw pushbuttons, asynchronous
- sw  in  10  raw switches, asynchronous
- hex  out  24  HEX register
- ledr  out  10  LEDR register
- fwdValue_m  out  DBITS  MEM-stage forward value
- fwdValid_m  out  1  forward value usable this cycle
- regWrite_w  out  1  writeback enable
- dstReg_w  out  DBITS  writeback destination
- wbData_w  out  DBITS  writeback data

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low on reset_n. All flops clear on reset_n=0: regWrite_w=0, dstReg_w=0, hex=0, ledr=0, all internal WB and sync registers 0, so wbData_w=0.
- Data-RAM contents are not reset.
- Address decode uses aluOut_m; bits [1:0] are ignored (word access only).
  - RAM hit: aluOut_m[DBITS-1:MEM_ADDR_BITS+2]==0; RAM index is aluOut_m[MEM_ADDR_BITS+1:2].
  - Any other address not equal to an MMIO address is unmapped.
- Stores: at posedge with memWrite_m=1:
  - RAM hit: write RAM word.
  - ADDR_HEX: hex<=dataFwdOut2_m[23:0].
  - ADDR_LEDR: ledr<=dataFwdOut2_m[9:0].
  - KEY, SW or unmapped: no effect.
  - No store takes effect while reset_n=0.
- Loads: RAM is synchronous-read. Address is presented in MEM and data is registered at the same posedge as the MEM/WB register (1-cycle latency, aligned with WB).
  - MMIO read data is muxed and registered at the same edge, zero-extended.
  - Unmapped reads return 0.
  - A load and a store to the same address in one cycle cannot occur (single instruction per stage).
- key/sw pass through a 2-flop synchronizer before being readable; value visible to loads 2 cycles after pin change.
- MEM/WB register, every posedge: captures regWrite_m, dstReg_m, memtoReg_m, jal_m, aluOut_m, incrementedPC_m, plus registered read data. No stall or flush input; the upstream flush already clears regWrite/memWrite.
- wbData_w is combinational from WB registers, with priority: memtoReg ? readData : jal ? incrementedPC : aluOut.
- Forwarding:
  - fwdValue_m = jal_m ? incrementedPC_m : aluOut_m.
  - fwdValid_m = regWrite_m & ~memtoReg_m. Load data is not forwardable from MEM; the hazard unit stalls.
- Latency: store side effect at the first posedge after MEM entry; wbData_w is valid for one cycle after that edge.

Decomposition:
- Shared package holds the MMIO address constants, DBITS, and the writeback-select encoding.
- One natural sub-module: data_ram (single-port, synchronous-read, write-enable, DBITS wide, 2^MEM_ADDR_BITS deep, inferable as block RAM).
- Synchronizers and MMIO registers stay in mem_stage.

Test Plan:
- Store/load RAM: store 0xDEADBEEF to 0x00000010, then load 0x00000010 with dstReg_m=5 → next-cycle wbData_w=0xDEADBEEF, regWrite_w=1, dstReg_w=5.
- Address bits [1:0] ignored: load 0x00000013 after the above → wbData_w=0xDEADBEEF.
- MMIO writes: store 0x00ABCDEF to ADDR_HEX and 0x3FF to ADDR_LEDR → hex=0xABCDEF, ledr=0x3FF after the edge; store to ADDR_SW → no change anywhere.
- Input sync: set sw=0x155, wait 2 cycles, load ADDR_SW → wbData_w=0x00000155; load 0x80000000 (unmapped) → 0.
- Writeback select: jal_m=1, incrementedPC_m=0x104, aluOut_m=0x7 → wbData_w=0x104, fwdValue_m=0x104, fwdValid_m=1; memtoReg_m=1 → fwdValid_m=0.
- Async reset mid-operation: assert reset_n=0 between edges while memWrite_m=1 targeting ADDR_HEX → regWrite_w, hex, ledr, wbData_w go to 0 immediately; hex stays 0 after release until the next store.
